imm_encoder: RTL and testbench
==============================

# imm_encoder

Instruction-word assembler for the single-cycle RISC-V core; the inverse of the immediate extender. It accepts field-level encode requests (format, opcode, registers, funct3, full 32-bit immediate) over a valid/ready handshake. It scatters the immediate into the RV32I I/S/B/J bit positions, range-checks it and writes the packed word into the instruction memory's write port at consecutive word addresses. Used by the test/boot loader to build programs in instruction memory without a host-side assembler.

## Interface
- `ADDR_W`, 8: instruction-memory word-address width.
- `BASE_ADDR`, 0: first word address written after `start`.
- `DEPTH`, 256: maximum words per load session.
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  one-cycle pulse; begins a load session.
- `in_valid`  in  1  request valid.
- `in_ready`  out  1  request accepted when `in_valid & in_ready`.
- `in_last`  in  1  final request of session.
- `imm_src`  in  2  format: 00 I, 01 S, 10 B, 11 J (same code as extender).
- `opcode`  in  7  instr[6:0].
- `rd`  in  5  instr[11:7] (I, J only).
- `funct3`  in  3  instr[14:12] (I, S, B only).
- `rs1`  in  5  instr[19:15] (I, S, B only).
- `rs2`  in  5  instr[24:20] (S, B only).
- `imm`  in  32  signed immediate, byte offset for B/J.
- `imem_we`  out  1  write strobe.
- `imem_addr`  out  ADDR_W  word address.
- `imem_wdata`  out  32  encoded instruction.
- `done`  out  1  one-cycle pulse at session end.
- `err`  out  1  sticky: an immediate failed its check this session.
- `err_addr`  out  ADDR_W  address of first failing word.

## Operation
- FSM states: IDLE, LOAD, DONE.
  - IDLE: `in_ready`=0. `start` moves to LOAD, sets the address counter to `BASE_ADDR`, clears `err`/`err_addr`.
  - LOAD: `in_ready`=1. Accepting with `in_last`=1, or accepting the DEPTH-th word, moves to DONE. `start` is ignored.
  - DONE: `in_ready`=0, `done`=1 for one cycle, then IDLE.
- Field placement:
  - Unused register and funct fields are zero per format. I: rd, funct3, rs1. S: funct3, rs1, rs2. B: funct3, rs1, rs2. J: rd.
  - I: [31:20]=imm[11:0].
  - S: [31:25]=imm[11:5], [11:7]=imm[4:0].
  - B: [31]=imm[12], [30:25]=imm[10:5], [11:8]=imm[4:1], [7]=imm[11].
  - J: [31]=imm[20], [30:21]=imm[10:1], [20]=imm[11], [19:12]=imm[19:12].
- Range rules:
  - I/S: −2048..2047.
  - B: −4096..4094 and imm[0]=0.
  - J: −1048576..1048574 and imm[0]=0.
- Failing request:
  - Word written is NOP 0x00000013.
  - `err` set; `err_addr` captured only if `err` was 0.
  - The address still advances.
- Property: feeding `imem_wdata[31:7]` and `imm_src` to the extender returns `imm` for every in-range request.

## Timing
- Reset values: state IDLE, `in_ready`=0, `imem_we`=0, `imem_addr`=`BASE_ADDR`, `imem_wdata`=0, `done`=0, `err`=0, `err_addr`=0.
- Latency 1:
  - Accept at cycle N gives `imem_we`=1 at N+1, with registered addr/data.
  - The counter increments after each write.
- Throughput 1 word/cycle.
- Final accept at N: state DONE and `done`=1 at N+1, coincident with the final write. IDLE at N+2.
- `start` in the same cycle as DONE is ignored. `start` in IDLE takes effect on the next edge, so the first accept is possible at N+1.
- Address wraps modulo 2^ADDR_W if `BASE_ADDR`+DEPTH exceeds the space. No error is flagged.
- `rst` mid-session drops any pending write; `imem_we`=0 the next cycle.

## Configuration
- `IMM_CHECK_EN` defined: range/alignment checks, NOP substitution and `err`/`err_addr` behave as above.
- `IMM_CHECK_EN` undefined:
  - No checks; immediates are truncated into their fields as given.
  - `err` and `err_addr` are tied to 0.

## Test plan
- Start, then I, rd=1, rs1=0, funct3=0, opcode=0x13, imm=5 -> write 0x00500093 at `BASE_ADDR` one cycle after accept.
- Back-to-back accepts:
  - S, opcode=0x23, funct3=2, rs1=1, rs2=2, imm=8 -> 0x0020A423.
  - B, opcode=0x63, funct3=0, rs1=0, rs2=0, imm=−4 -> 0xFE000EE3 at the next address.
- J, rd=1, opcode=0x6F, imm=2048, `in_last`=1 -> 0x001000EF. `done` pulses in the same cycle. `in_ready` low afterwards.
- With `IMM_CHECK_EN`:
  - I imm=2048 at addr 3 -> 0x00000013 written, `err`=1, `err_addr`=3.
  - A later B imm=3 keeps `err_addr`=3.
- Issue DEPTH=4 requests without `in_last` -> exactly 4 writes; DONE after the 4th. Assert `rst` during LOAD -> no further `imem_we`, outputs at reset values.
- Random in-range requests through the extender -> recovered immediate equals `imm` for all four formats.

Source files
------------

// File: rtl/imm_encoder.sv
// imm_encoder: packs field-level encode requests into RV32I I/S/B/J words and streams them into
// instruction memory. Define IMM_CHECK_EN to enable immediate range checks and err reporting.
module imm_encoder #(
    parameter int unsigned ADDR_W    = 8,
    parameter int unsigned BASE_ADDR = 0,
    parameter int unsigned DEPTH     = 256
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_last,
    input  logic [1:0]        imm_src,
    input  logic [6:0]        opcode,
    input  logic [4:0]        rd,
    input  logic [2:0]        funct3,
    input  logic [4:0]        rs1,
    input  logic [4:0]        rs2,
    input  logic [31:0]       imm,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              done,
    output logic              err,
    output logic [ADDR_W-1:0] err_addr
);
    localparam int unsigned       CNT_W = $clog2(DEPTH + 1);
    localparam logic [ADDR_W-1:0] BASE  = ADDR_W'(BASE_ADDR);
    localparam logic [31:0]       NOP   = 32'h0000_0013;

    typedef enum logic [1:0] {StIdle, StLoad, StDone} state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] ptr_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              accept;
    logic              session_end;
    logic              open_session;
    logic              imm_ok;
    logic [31:0]       word;

    assign in_ready     = (state_q == StLoad);
    assign done         = (state_q == StDone);
    assign accept       = in_valid & in_ready;
    assign open_session = (state_q == StIdle) & start;
    assign session_end  = accept & (in_last | (cnt_q == CNT_W'(DEPTH - 1)));

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (start) state_d = StLoad;
            StLoad:  if (session_end) state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Scatter the immediate; fields a format does not use stay zero.
    always_comb begin
        word = 32'h0;
        unique case (imm_src)
            2'b00: word = {imm[11:0], rs1, funct3, rd, opcode};
            2'b01: word = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
            2'b10: word = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
            2'b11: word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
            default: word = 32'h0;
        endcase
    end

`ifdef IMM_CHECK_EN
    logic              err_q;
    logic [ADDR_W-1:0] err_addr_q;

    // In range means every bit above the field's sign bit replicates it.
    always_comb begin
        imm_ok = 1'b1;
        unique case (imm_src)
            2'b00, 2'b01: imm_ok = (imm[31:11] == '0) || (imm[31:11] == '1);
            2'b10: imm_ok = ((imm[31:12] == '0) || (imm[31:12] == '1)) && !imm[0];
            2'b11: imm_ok = ((imm[31:20] == '0) || (imm[31:20] == '1)) && !imm[0];
            default: imm_ok = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst || open_session) begin
            err_q      <= 1'b0;
            err_addr_q <= '0;
        end else if (accept && !imm_ok) begin
            err_q <= 1'b1;
            if (!err_q) err_addr_q <= ptr_q;
        end
    end

    assign err      = err_q;
    assign err_addr = err_addr_q;
`else
    logic unused_imm;

    assign imm_ok     = 1'b1;
    assign unused_imm = ^imm[31:21];
    assign err        = 1'b0;
    assign err_addr   = '0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            ptr_q      <= BASE;
            cnt_q      <= '0;
            imem_we    <= 1'b0;
            imem_addr  <= BASE;
            imem_wdata <= 32'h0;
        end else begin
            state_q <= state_d;
            imem_we <= accept;
            if (open_session) begin
                ptr_q <= BASE;
                cnt_q <= '0;
            end
            if (accept) begin
                imem_addr  <= ptr_q;
                imem_wdata <= imm_ok ? word : NOP;
                ptr_q      <= ptr_q + 1'b1;
                cnt_q      <= cnt_q + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_imm_encoder.sv
// Scoreboard bench for imm_encoder: expected writes are queued at accept and matched against
// the memory write port; in-range immediates are also recovered through a reference extender.
module tb_imm_encoder;
    localparam int unsigned ADDR_W    = 2;
    localparam int unsigned BASE_ADDR = 2;
    localparam int unsigned DEPTH     = 4;
    localparam logic [31:0] NOP       = 32'h0000_0013;
`ifdef IMM_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic              in_valid;
    logic              in_ready;
    logic              in_last;
    logic [1:0]        imm_src;
    logic [6:0]        opcode;
    logic [4:0]        rd;
    logic [2:0]        funct3;
    logic [4:0]        rs1;
    logic [4:0]        rs2;
    logic [31:0]       imm;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic              done;
    logic              err;
    logic [ADDR_W-1:0] err_addr;

    imm_encoder #(
        .ADDR_W   (ADDR_W),
        .BASE_ADDR(BASE_ADDR),
        .DEPTH    (DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_last   (in_last),
        .imm_src   (imm_src),
        .opcode    (opcode),
        .rd        (rd),
        .funct3    (funct3),
        .rs1       (rs1),
        .rs2       (rs2),
        .imm       (imm),
        .imem_we   (imem_we),
        .imem_addr (imem_addr),
        .imem_wdata(imem_wdata),
        .done      (done),
        .err       (err),
        .err_addr  (err_addr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [31:0]       data;
        logic              done;
        logic              err;
        logic [ADDR_W-1:0] err_addr;
        logic [1:0]        src;
        logic [31:0]       imm;
        logic              in_range;
    } exp_t;

    exp_t              sb_q[$];
    exp_t              mon_e;
    int                n_checks = 0;
    int                n_fail = 0;
    logic              mon_en = 1'b0;
    logic [ADDR_W-1:0] ptr_m;
    logic [ADDR_W-1:0] err_addr_m;
    logic              err_m;
    int                cnt_m;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic bit in_range(input logic [1:0] src, input logic [31:0] im);
        int v;
        v = int'(im);
        case (src)
            2'd0, 2'd1: return (v >= -2048) && (v <= 2047);
            2'd2:       return (v >= -4096) && (v <= 4094) && !im[0];
            default:    return (v >= -1048576) && (v <= 1048574) && !im[0];
        endcase
    endfunction

    function automatic logic [31:0] encode(input logic [1:0] src, input logic [6:0] op,
                                           input logic [4:0] a_rd, input logic [2:0] f3,
                                           input logic [4:0] r1, input logic [4:0] r2,
                                           input logic [31:0] im);
        logic [31:0] w;
        case (src)
            2'd0: w = ((im & 32'hFFF) << 20) | (32'(r1) << 15) | (32'(f3) << 12)
                      | (32'(a_rd) << 7);
            2'd1: w = (((im >> 5) & 32'h7F) << 25) | (32'(r2) << 20) | (32'(r1) << 15)
                      | (32'(f3) << 12) | ((im & 32'h1F) << 7);
            2'd2: w = (((im >> 12) & 32'h1) << 31) | (((im >> 5) & 32'h3F) << 25)
                      | (32'(r2) << 20) | (32'(r1) << 15) | (32'(f3) << 12)
                      | (((im >> 1) & 32'hF) << 8) | (((im >> 11) & 32'h1) << 7);
            default: w = (((im >> 20) & 32'h1) << 31) | (((im >> 1) & 32'h3FF) << 21)
                      | (((im >> 11) & 32'h1) << 20) | (((im >> 12) & 32'hFF) << 12)
                      | (32'(a_rd) << 7);
        endcase
        return w | 32'(op);
    endfunction

    // Reference immediate extender (decoder side).
    function automatic logic [31:0] extend(input logic [31:0] w, input logic [1:0] src);
        case (src)
            2'd0:    return {{20{w[31]}}, w[31:20]};
            2'd1:    return {{20{w[31]}}, w[31:25], w[11:7]};
            2'd2:    return {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
            default: return {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
        endcase
    endfunction

    always @(negedge clk) begin
        if (mon_en) begin
            if (imem_we) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_we", 32'(imem_we), 32'h0);
                end else begin
                    mon_e = sb_q.pop_front();
                    check("wr_addr", 32'(imem_addr), 32'(mon_e.addr));
                    check("wr_data", imem_wdata, mon_e.data);
                    check("done_with_write", 32'(done), 32'(mon_e.done));
                    check("err", 32'(err), 32'(mon_e.err));
                    check("err_addr", 32'(err_addr), 32'(mon_e.err_addr));
                    if (mon_e.in_range)
                        check("ext_round_trip", extend(imem_wdata, mon_e.src), mon_e.imm);
                end
            end else if (done) begin
                check("stray_done", 32'(done), 32'h0);
            end
        end
    end

    task automatic send(input logic [1:0] src, input logic [6:0] op, input logic [4:0] a_rd,
                        input logic [2:0] f3, input logic [4:0] r1, input logic [4:0] r2,
                        input logic [31:0] im, input logic last, input logic [31:0] want,
                        input bit have_want);
        exp_t e;
        int   budget;
        bit   ok;
        budget   = 20;
        imm_src  = src;
        opcode   = op;
        rd       = a_rd;
        funct3   = f3;
        rs1      = r1;
        rs2      = r2;
        imm      = im;
        in_last  = last;
        in_valid = 1'b1;
        while (!in_ready && budget > 0) begin
            @(posedge clk);
            #1;
            budget--;
        end
        if (!in_ready) begin
            check("accept_timeout", 32'h0, 32'h1);
            in_valid = 1'b0;
            in_last  = 1'b0;
            return;
        end
        cnt_m++;
        ok     = !CHK || in_range(src, im);
        e.addr = ptr_m;
        ptr_m  = ptr_m + 1'b1;
        e.data = have_want ? want : (ok ? encode(src, op, a_rd, f3, r1, r2, im) : NOP);
        if (!ok) begin
            if (!err_m) err_addr_m = e.addr;
            err_m = 1'b1;
        end
        e.err      = err_m;
        e.err_addr = err_addr_m;
        e.done     = last || (cnt_m == DEPTH);
        e.src      = src;
        e.imm      = im;
        e.in_range = in_range(src, im);
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic rand_send(input logic last);
        logic [1:0] src;
        int         v;
        src = 2'($urandom_range(0, 3));
        case (src)
            2'd0, 2'd1: v = int'($urandom_range(0, 4095)) - 2048;
            2'd2:       v = (int'($urandom_range(0, 4095)) - 2048) * 2;
            default:    v = (int'($urandom_range(0, 1048575)) - 524288) * 2;
        endcase
        send(src, 7'($urandom), 5'($urandom), 3'($urandom), 5'($urandom), 5'($urandom),
             32'(v), last, 32'h0, 1'b0);
    endtask

    task automatic begin_session();
        start = 1'b1;
        @(posedge clk);
        #1;
        start      = 1'b0;
        ptr_m      = ADDR_W'(BASE_ADDR);
        cnt_m      = 0;
        err_m      = 1'b0;
        err_addr_m = '0;
        check("start_clears_err", 32'(err), 32'h0);
        check("start_clears_err_addr", 32'(err_addr), 32'h0);
    endtask

    task automatic finish_session();
        check("ready_low_in_done", 32'(in_ready), 32'h0);
        @(posedge clk);
        #1;
        check("ready_low_in_idle", 32'(in_ready), 32'h0);
        check("done_one_cycle", 32'(done), 32'h0);
    endtask

    initial begin
        rst      = 1'b1;
        start    = 1'b0;
        in_valid = 1'b0;
        in_last  = 1'b0;
        imm_src  = '0;
        opcode   = '0;
        rd       = '0;
        funct3   = '0;
        rs1      = '0;
        rs2      = '0;
        imm      = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", 32'(in_ready), 32'h0);
        check("rst_imem_we", 32'(imem_we), 32'h0);
        check("rst_imem_addr", 32'(imem_addr), BASE_ADDR);
        check("rst_imem_wdata", imem_wdata, 32'h0);
        check("rst_done", 32'(done), 32'h0);
        check("rst_err", 32'(err), 32'h0);
        check("rst_err_addr", 32'(err_addr), 32'h0);
        rst    = 1'b0;
        mon_en = 1'b1;
        @(posedge clk);
        #1;

        // Directed words, DEPTH reached together with in_last.
        begin_session();
        send(2'd0, 7'h13, 5'd1, 3'd0, 5'd0, 5'd0, 32'd5, 1'b0, 32'h0050_0093, 1'b1);
        send(2'd1, 7'h23, 5'd0, 3'd2, 5'd1, 5'd2, 32'd8, 1'b0, 32'h0020_A423, 1'b1);
        send(2'd2, 7'h63, 5'd0, 3'd0, 5'd0, 5'd0, -32'sd4, 1'b0, 32'hFE00_0EE3, 1'b1);
        send(2'd3, 7'h6F, 5'd1, 3'd0, 5'd0, 5'd0, 32'd2048, 1'b1, 32'h0010_00EF, 1'b1);
        check("ready_low_after_last", 32'(in_ready), 32'h0);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        #1;
        check("start_in_done_ignored", 32'(in_ready), 32'h0);

        // in_last ends a short session.
        begin_session();
        send(2'd0, 7'h13, 5'd1, 3'd0, 5'd0, 5'd0, 32'd5, 1'b0, 32'h0050_0093, 1'b1);
        send(2'd3, 7'h6F, 5'd1, 3'd0, 5'd0, 5'd0, 32'd2048, 1'b1, 32'h0010_00EF, 1'b1);
        finish_session();

        // DEPTH words without in_last; a fifth request must not be written.
        begin_session();
        for (int i = 0; i < 4; i++) rand_send(1'b0);
        in_valid = 1'b1;
        check("ready_low_after_depth", 32'(in_ready), 32'h0);
        repeat (3) @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("idle_after_depth", 32'(in_ready), 32'h0);

        // Out-of-range immediates (NOP and sticky err when checking is built in).
        begin_session();
        send(2'd0, 7'h13, 5'd1, 3'd0, 5'd0, 5'd0, 32'd5, 1'b0, 32'h0, 1'b0);
        send(2'd0, 7'h13, 5'd1, 3'd0, 5'd2, 5'd0, 32'd2048, 1'b0, 32'h0, 1'b0);
        send(2'd2, 7'h63, 5'd0, 3'd1, 5'd3, 5'd4, 32'd3, 1'b0, 32'h0, 1'b0);
        send(2'd3, 7'h6F, 5'd5, 3'd0, 5'd0, 5'd0, 32'd2048, 1'b1, 32'h0, 1'b0);
        finish_session();

        // Random in-range sessions with idle gaps.
        for (int s = 0; s < 8; s++) begin
            int len;
            begin_session();
            len = int'($urandom_range(1, 4));
            for (int i = 0; i < len; i++) begin
                repeat ($urandom_range(0, 2)) begin
                    @(posedge clk);
                    #1;
                end
                rand_send((i == len - 1) && ((len < 4) || ($urandom_range(0, 1) == 1)));
            end
            finish_session();
        end

        // Reset mid-session drops the pending request.
        begin_session();
        rand_send(1'b0);
        imm_src  = 2'd0;
        imm      = 32'd7;
        in_valid = 1'b1;
        rst      = 1'b1;
        @(negedge clk);
        #1;
        mon_en = 1'b0;
        @(posedge clk);
        #1;
        check("midrst_imem_we", 32'(imem_we), 32'h0);
        check("midrst_in_ready", 32'(in_ready), 32'h0);
        check("midrst_imem_addr", 32'(imem_addr), BASE_ADDR);
        check("midrst_imem_wdata", imem_wdata, 32'h0);
        check("midrst_done", 32'(done), 32'h0);
        check("midrst_err", 32'(err), 32'h0);
        check("midrst_sb_empty", 32'(sb_q.size()), 32'h0);
        rst      = 1'b0;
        in_valid = 1'b0;
        mon_en   = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("post_rst_idle", 32'(in_ready), 32'h0);

        for (int i = 0; i < 10 && sb_q.size() != 0; i++) @(posedge clk);
        check("sb_drained", 32'(sb_q.size()), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
